// File: rtl/mac_sequencer_pkg.sv
// Shared widths and state encoding for the mac_sequencer dot-product engine.
//   DATA_WIDTH_DEF   : default width of operands, bias, accumulator and result
//   WEIGHT_WIDTH_DEF : default width of the weight operand
//   LENGTH_WIDTH_DEF : default width of the pair counter
package mac_sequencer_pkg;

  localparam int unsigned DATA_WIDTH_DEF   = 32;
  localparam int unsigned WEIGHT_WIDTH_DEF = 8;
  localparam int unsigned LENGTH_WIDTH_DEF = 8;

  // Encoding 2'd3 is unreachable and is treated as IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/mac_sequencer_multiply_and_add.sv
// Combinational multiply-accumulate: output_value_c = add_value + input_value * weight_value.
//   add_value      : running sum
//   input_value    : activation operand
//   weight_value   : weight operand, zero-extended to DATA_WIDTH
//   output_value_c : sum truncated modulo 2^DATA_WIDTH
module multiply_and_add #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned WEIGHT_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0]   add_value,
  input  logic [DATA_WIDTH-1:0]   input_value,
  input  logic [WEIGHT_WIDTH-1:0] weight_value,
  output logic [DATA_WIDTH-1:0]   output_value_c
);

  logic [DATA_WIDTH-1:0] weight_ext;

  assign weight_ext     = DATA_WIDTH'(weight_value);
  // Product and sum both wrap silently at DATA_WIDTH bits.
  assign output_value_c = add_value + input_value * weight_ext;

endmodule

// File: rtl/mac_sequencer.sv
// Multi-cycle dot-product engine for one neuron: loads a bias, accumulates
// (input, weight) pairs at one per cycle and presents the sum on a
// valid/ready result port.
//   clk, rst                  : clock, synchronous active-high reset
//   start, vector_length,
//   bias_value                : job request and parameters (latched in IDLE)
//   in_valid/in_ready,
//   input_value, weight_value : pair stream
//   result_valid/result_ready,
//   result_value              : finished sum
//   busy                      : high whenever not IDLE
module mac_sequencer
  import mac_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int unsigned WEIGHT_WIDTH = WEIGHT_WIDTH_DEF,
  parameter int unsigned LENGTH_WIDTH = LENGTH_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LENGTH_WIDTH-1:0] vector_length,
  input  logic [DATA_WIDTH-1:0]   bias_value,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   input_value,
  input  logic [WEIGHT_WIDTH-1:0] weight_value,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [DATA_WIDTH-1:0]   result_value,
  output logic                    busy
);

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic [LENGTH_WIDTH-1:0] rem_q, rem_d;
  logic                    in_ready_q, in_ready_d;
  logic                    result_valid_q, result_valid_d;
  logic                    busy_q, busy_d;
  logic [DATA_WIDTH-1:0]   mac_sum_c;
  logic                    beat_c;

  // Datapath: accumulator fed back as the add operand.
  multiply_and_add #(
    .DATA_WIDTH   (DATA_WIDTH),
    .WEIGHT_WIDTH (WEIGHT_WIDTH)
  ) u_mac (
    .add_value      (acc_q),
    .input_value    (input_value),
    .weight_value   (weight_value),
    .output_value_c (mac_sum_c)
  );

  // in_ready_q is only ever high in ACCUM, so it alone qualifies a beat.
  assign beat_c = in_valid & in_ready_q;

  // Next-state, counter/accumulator update and registered-output decode.
  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    rem_d          = rem_q;
    in_ready_d     = 1'b0;
    result_valid_d = 1'b0;
    busy_d         = 1'b0;

    case (state_q)
      ST_ACCUM: begin
        if (beat_c) begin
          acc_d = mac_sum_c;
          rem_d = rem_q - LENGTH_WIDTH'(1);
          if (rem_q == LENGTH_WIDTH'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // A start seen here is dropped; it must be re-presented in IDLE.
        if (result_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        if (start) begin
          acc_d   = bias_value;
          rem_d   = vector_length;
          state_d = (vector_length != '0) ? ST_ACCUM : ST_DONE;
        end
      end
    endcase

    // Outputs are decoded from the next state so they register with it.
    in_ready_d     = (state_d == ST_ACCUM);
    result_valid_d = (state_d == ST_DONE);
    busy_d         = (state_d == ST_ACCUM) || (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      acc_q          <= '0;
      rem_q          <= '0;
      in_ready_q     <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      rem_q          <= rem_d;
      in_ready_q     <= in_ready_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign result_valid = result_valid_q;
  assign result_value = acc_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer: directed jobs from the test plan
// followed by randomized jobs checked against a plain-arithmetic dot-product model.
module tb_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  vector_length;
  logic [31:0] bias_value;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] input_value;
  logic [7:0]  weight_value;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] result_value;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  mac_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .vector_length (vector_length),
    .bias_value    (bias_value),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .input_value   (input_value),
    .weight_value  (weight_value),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .result_value  (result_value),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Dot product reference: bias + sum(x*w), reduced modulo 2^32.
  function automatic logic [31:0] model_dot(input logic [31:0] bias,
                                            input logic [31:0] xs[$],
                                            input logic [7:0] ws[$]);
    longint unsigned s;
    s = longint'(bias);
    foreach (xs[i]) s = (s + longint'(xs[i]) * longint'(ws[i])) % 64'h1_0000_0000;
    return 32'(s);
  endfunction

  task automatic run_job(input logic [31:0] bias, input logic [31:0] xs[$],
                         input logic [7:0] ws[$], input int gap_pct, input int hold);
    int          len;
    int          gaps;
    logic [31:0] exp;
    len = xs.size();
    exp = model_dot(bias, xs, ws);

    // Noise in IDLE must not count as a beat.
    in_valid      = 1'($urandom_range(0, 1));
    input_value   = $urandom;
    weight_value  = 8'($urandom);
    result_ready  = 1'($urandom_range(0, 1));
    start         = 1'b1;
    vector_length = 8'(len);
    bias_value    = bias;
    tick();
    start         = 1'b0;
    vector_length = 8'($urandom);
    bias_value    = $urandom;
    result_ready  = 1'b0;
    check_eq("busy_after_start", 32'(busy), 32'd1);

    if (len == 0) begin
      check_eq("len0_valid", 32'(result_valid), 32'd1);
      check_eq("len0_in_ready", 32'(in_ready), 32'd0);
    end else begin
      check_eq("accum_in_ready", 32'(in_ready), 32'd1);
      check_eq("accum_no_valid", 32'(result_valid), 32'd0);
      for (int i = 0; i < len; i++) begin
        gaps = 0;
        while (gaps < 3 && $urandom_range(0, 99) < 32'(gap_pct)) begin
          in_valid     = 1'b0;
          input_value  = $urandom;
          weight_value = 8'($urandom);
          start        = 1'($urandom_range(0, 1));
          tick();
          check_eq("gap_hold_ready", 32'(in_ready), 32'd1);
          check_eq("gap_hold_valid", 32'(result_valid), 32'd0);
          gaps++;
        end
        in_valid     = 1'b1;
        input_value  = xs[i];
        weight_value = ws[i];
        start        = 1'($urandom_range(0, 1));
        tick();
        check_eq("valid_after_beat", 32'(result_valid), (i == len - 1) ? 32'd1 : 32'd0);
        check_eq("ready_after_beat", 32'(in_ready), (i == len - 1) ? 32'd0 : 32'd1);
      end
      start = 1'b0;
    end

    check_eq("result_value", result_value, exp);

    // Back-pressure: result held stable, start ignored.
    in_valid = 1'($urandom_range(0, 1));
    for (int h = 0; h < hold; h++) begin
      start         = (h == 1);
      vector_length = 8'($urandom);
      bias_value    = $urandom;
      in_valid      = 1'($urandom_range(0, 1));
      tick();
      check_eq("hold_valid", 32'(result_valid), 32'd1);
      check_eq("hold_value", result_value, exp);
      check_eq("hold_in_ready", 32'(in_ready), 32'd0);
    end

    // Accept together with start: only IDLE is entered.
    result_ready = 1'b1;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    result_ready = 1'b0;
    in_valid     = 1'b0;
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("idle_valid", 32'(result_valid), 32'd0);
    check_eq("idle_in_ready", 32'(in_ready), 32'd0);
    tick();
    check_eq("start_not_reused", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [31:0] xq[$];
    logic [7:0]  wq[$];
    int          len;

    rst = 1'b1; start = 1'b0; vector_length = '0; bias_value = '0;
    in_valid = 1'b0; input_value = '0; weight_value = '0; result_ready = 1'b0;
    tick();
    tick();
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_valid", 32'(result_valid), 32'd0);
    check_eq("rst_value", result_value, 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    xq = '{32'd5}; wq = '{8'd2};
    run_job(32'd10, xq, wq, 0, 0);
    check_eq("dir1_expect", model_dot(32'd10, xq, wq), 32'd20);

    xq = '{32'd2, 32'd4, 32'd1}; wq = '{8'd3, 8'd5, 8'd7};
    run_job(32'd1, xq, wq, 0, 1);

    xq = {}; wq = {};
    run_job(32'd9, xq, wq, 0, 2);

    xq = '{32'd1}; wq = '{8'd1};
    run_job(32'hFFFF_FFFF, xq, wq, 0, 5);

    // Reset mid-job discards the partial sum.
    start = 1'b1; vector_length = 8'd4; bias_value = 32'd1234;
    tick();
    start = 1'b0;
    in_valid = 1'b1; input_value = 32'd7; weight_value = 8'd9;
    tick();
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1; input_value = 32'd11; weight_value = 8'd13;
    tick();
    rst = 1'b1; start = 1'b1; result_ready = 1'b1;
    tick();
    check_eq("midrst_in_ready", 32'(in_ready), 32'd0);
    check_eq("midrst_valid", 32'(result_valid), 32'd0);
    check_eq("midrst_value", result_value, 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; result_ready = 1'b0;
    tick();
    check_eq("midrst_idle", 32'(busy), 32'd0);
    xq = '{32'd3}; wq = '{8'd3};
    run_job(32'd0, xq, wq, 0, 0);

    // Randomized jobs.
    for (int j = 0; j < 40; j++) begin
      xq = {}; wq = {};
      len = (j % 10 == 9) ? 0 : int'($urandom_range(1, 7));
      for (int k = 0; k < len; k++) begin
        xq.push_back((j % 3 == 0) ? $urandom : 32'($urandom_range(0, 1000)));
        wq.push_back(8'($urandom));
      end
      run_job((j % 4 == 0) ? $urandom : 32'($urandom_range(0, 100)), xq, wq, 30,
              int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
